five_bit_down_counter: RTL
==========================

FIVE_BIT_DOWN_COUNTER -- requirements
Module: five_bit_down_counter

Interface
REQ-001 Parameter WIDTH, default 5: width of max and count.
REQ-002 Parameter DEBOUNCE_CYCLES, default 16: number of consecutive stable sampled cycles required to accept a button press or release (legal range 2..65535).
REQ-003 clock  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 resetn  input  1  asynchronous, active-low reset; asserting it SHALL clear all state immediately, and deassertion is synchronous to clock.
REQ-005 max  input  WIDTH  wrap-back value; sampled synchronously.
REQ-006 btn  input  1  raw, bouncy, asynchronous push-button level; 1 = pressed.
REQ-007 load  input  1  synchronous preset; when 1, count SHALL take max on the next edge.
REQ-008 count  output  WIDTH  registered counter value.
REQ-009 zero  output  1  SHALL equal (count == 0), derived combinationally from the count register.
REQ-010 dec_pulse  output  1  registered, one cycle high per accepted press.
REQ-011 wrap  output  1  registered, one cycle high when a decrement reloads max.

Function
REQ-012 btn SHALL pass through a two-flop synchronizer (sync); the FSM SHALL use only sync.
REQ-013 The debounce FSM SHALL have states IDLE, PRESS_CHK, HELD and REL_CHK, plus a stability counter of ceil(log2(DEBOUNCE_CYCLES)) bits.
REQ-014 IDLE: sync=1 -> PRESS_CHK with the stability counter cleared to 0; otherwise remain in IDLE.
REQ-015 PRESS_CHK: sync=0 -> IDLE; sync=1 with counter = DEBOUNCE_CYCLES-1 -> HELD (accepted press); otherwise the counter increments.
REQ-016 HELD: sync=0 -> REL_CHK with the counter cleared; otherwise remain in HELD, with no further presses accepted.
REQ-017 REL_CHK: sync=1 -> HELD; sync=0 with counter = DEBOUNCE_CYCLES-1 -> IDLE; otherwise the counter increments.
REQ-018 On the edge taking PRESS_CHK -> HELD, dec_pulse SHALL be 1 for exactly that following cycle, and count SHALL update on that same edge.
REQ-019 Latency: for btn rising before edge 1 and held stable, count SHALL change at edge DEBOUNCE_CYCLES+3.
REQ-020 Decrement rule: if count = 0 or count > max, the next count SHALL be max and wrap SHALL be 1; otherwise the next count SHALL be count-1 and wrap SHALL be 0.
REQ-021 Arithmetic SHALL be unsigned, with no value outside 0..max ever produced by a decrement.
REQ-022 If load=1 on the same edge as an accepted press, load SHALL win: count=max, wrap=0, and dec_pulse still SHALL be 1.
REQ-023 When load=1 with no press, count=max and dec_pulse=wrap=0.
REQ-024 If max = 0, every accepted press SHALL yield count=0 and wrap=1.
REQ-025 A change of max SHALL NOT alter count until the next load or accepted press.

Reset
REQ-026 While resetn=0: count=0, zero=1, dec_pulse=0, wrap=0, FSM=IDLE, stability counter=0, synchronizer flops=0.
REQ-027 A reset asserted mid-PRESS_CHK or mid-REL_CHK SHALL abandon the press; after release, btn held high SHALL require a full new debounce before any decrement.

Verification (WIDTH=5, DEBOUNCE_CYCLES=4)
REQ-028 Reset: resetn=0 with btn toggling -> count=0, zero=1, dec_pulse=0, wrap=0 throughout.
REQ-029 Clean press: load with max=5, then btn=1 held -> count 5->4 at edge 7 after the btn rise, dec_pulse high for 1 cycle, wrap=0.
REQ-030 Glitch and bounce: btn high for 3 cycles then low -> no count change; btn held for 50 cycles with a 2-cycle bounce at release -> exactly one decrement.
REQ-031 Wrap: count=0, max=31, press -> count=31, wrap=1 for 1 cycle, zero 1->0.
REQ-032 Out of range: count=10, max changed to 3, press -> count=3, wrap=1.
REQ-033 Reset mid-debounce: resetn pulsed low during PRESS_CHK -> count=0 immediately; btn kept high -> decrement only 7 edges after resetn rises.

Source files
------------

// File: rtl/five_bit_down_counter.sv
// rtl/five_bit_down_counter.sv - debounced push-button down counter with wrap-back and preset
module five_bit_down_counter #(
  parameter int WIDTH           = 5,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic [WIDTH-1:0] max,
  input  logic             btn,
  input  logic             load,
  output logic [WIDTH-1:0] count,
  output logic             zero,
  output logic             dec_pulse,
  output logic             wrap
);

  // Stability counter only needs to reach DEBOUNCE_CYCLES-1.
  localparam int            CW          = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] STABLE_LAST = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_PRESS_CHK = 2'd1,
    S_HELD      = 2'd2,
    S_REL_CHK   = 2'd3
  } state_t;

  logic             r_sync_meta;
  logic             r_sync;
  state_t           r_state;
  state_t           w_state_next;
  logic [CW-1:0]    r_stable;
  logic [CW-1:0]    w_stable_next;
  logic             w_press;
  logic             w_out_of_range;
  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] w_count_next;
  logic             w_wrap_next;
  logic             r_dec_pulse;
  logic             r_wrap;

  // Two-flop synchronizer for the asynchronous button level.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_sync_meta <= 1'b0;
      r_sync      <= 1'b0;
    end else begin
      r_sync_meta <= btn;
      r_sync      <= r_sync_meta;
    end
  end

  // Debounce FSM state and stability counter registers.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state  <= S_IDLE;
      r_stable <= '0;
    end else begin
      r_state  <= w_state_next;
      r_stable <= w_stable_next;
    end
  end

  // Debounce next-state: a level must hold for DEBOUNCE_CYCLES checks to be accepted.
  always_comb begin
    w_state_next  = r_state;
    w_stable_next = r_stable;
    case (r_state)
      S_IDLE: begin
        if (r_sync) begin
          w_state_next  = S_PRESS_CHK;
          w_stable_next = '0;
        end
      end
      S_PRESS_CHK: begin
        if (!r_sync) begin
          w_state_next = S_IDLE;
        end else if (r_stable == STABLE_LAST) begin
          w_state_next = S_HELD;
        end else begin
          w_stable_next = r_stable + CW'(1);
        end
      end
      S_HELD: begin
        if (!r_sync) begin
          w_state_next  = S_REL_CHK;
          w_stable_next = '0;
        end
      end
      S_REL_CHK: begin
        if (r_sync) begin
          w_state_next = S_HELD;
        end else if (r_stable == STABLE_LAST) begin
          w_state_next = S_IDLE;
        end else begin
          w_stable_next = r_stable + CW'(1);
        end
      end
      default: begin
        w_state_next  = S_IDLE;
        w_stable_next = '0;
      end
    endcase
  end

  // Accepted press: the PRESS_CHK -> HELD transition.
  always_comb begin
    w_press = (r_state == S_PRESS_CHK) && r_sync && (r_stable == STABLE_LAST);
  end

  // Next counter value: load wins; a press wraps to max when at zero or above max.
  always_comb begin
    w_out_of_range = (r_count == '0) || (r_count > max);
    w_count_next   = r_count;
    w_wrap_next    = 1'b0;
    if (load) begin
      w_count_next = max;
    end else if (w_press) begin
      if (w_out_of_range) begin
        w_count_next = max;
        w_wrap_next  = 1'b1;
      end else begin
        w_count_next = r_count - WIDTH'(1);
      end
    end
  end

  // Counter and single-cycle event flags.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_count     <= '0;
      r_dec_pulse <= 1'b0;
      r_wrap      <= 1'b0;
    end else begin
      r_count     <= w_count_next;
      r_dec_pulse <= w_press;
      r_wrap      <= w_wrap_next;
    end
  end

  assign count     = r_count;
  assign zero      = (r_count == '0);
  assign dec_pulse = r_dec_pulse;
  assign wrap      = r_wrap;

endmodule
